// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game datapath.
// Colour encoding, LFSR constants and small helpers used by datapath and timer.
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT   = 16'hACE1;
  localparam int          MAX_ROUNDS_DEF = 32;

  function automatic logic [3:0] onehot(input colour_t c);
    logic [3:0] v;
    v = 4'b0000;
    v[c] = 1'b1;
    return v;
  endfunction

  // Galois right-shift step: feedback taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/simon_datapath_pulse_timer.sv
// Speed-dependent pulse generator: one-cycle tick every period cycles after a restart.
// Stays silent after reset until the first restart arms it.
module pulse_timer
  import simon_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned SPEED_STEP  = 2_500_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load_speed,
  input  logic       flash_clk,
  input  logic [2:0] speed,
  output logic       pulse
);

  localparam logic [31:0] BASE_P = 32'(BASE_PERIOD);
  localparam logic [31:0] STEP_P = 32'(SPEED_STEP);
  localparam logic [31:0] MIN_P  = 32'(MIN_PERIOD);

  logic [31:0] step_total;
  logic [31:0] period;
  logic [31:0] tmr;
  logic        flash_q;
  logic        armed;
  logic        restart;

  always_comb begin
    step_total = 32'(speed) * STEP_P;
    period     = MIN_P;
    // Guard the subtraction so large speed levels clamp instead of wrapping.
    if (step_total < BASE_P) begin
      if ((BASE_P - step_total) > MIN_P) begin
        period = BASE_P - step_total;
      end
    end
  end

  assign restart = start | load_speed | (flash_clk & ~flash_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr     <= BASE_P - 32'd1;
      pulse   <= 1'b0;
      flash_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      flash_q <= flash_clk;
      if (restart) begin
        tmr   <= period - 32'd1;
        pulse <= 1'b0;
        armed <= 1'b1;
      end else if (!armed) begin
        pulse <= 1'b0;
      end else if (tmr == 32'd0) begin
        tmr   <= period - 32'd1;
        pulse <= 1'b1;
      end else begin
        tmr   <= tmr - 32'd1;
        pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: seed counter, colour LFSR and sequence store, pick compare, LED drive.
// Answers FSM strobes with result (combinational) and pulse (from pulse_timer).
module simon_datapath
  import simon_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned SPEED_STEP  = 2_500_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned MAX_ROUNDS  = MAX_ROUNDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       load_speed,
  input  logic       flash_clk,
  input  logic [2:0] speed,
  input  logic [5:0] check_round,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic       result,
  output logic [3:0] led,
  output logic [5:0] colour_count
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_ROUNDS);

  logic [15:0] seedgen;
  logic [15:0] lfsr;
  logic [3:0]  pick;
  logic [5:0]  check_q;
  colour_t     store [32];
  logic        col_wr;
  logic [4:0]  rd_idx;
  colour_t     exp_colour;
  logic [3:0]  exp_oh;

  // start outranks load_colour so a new game never inherits a stray colour.
  assign col_wr = load_colour & ~start & (colour_count < MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seedgen <= 16'h0000;
    end else if (rst_seedgen) begin
      seedgen <= 16'h0000;
    end else begin
      seedgen <= seedgen + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_DEFAULT;
    end else if (start) begin
      lfsr <= (seedgen == 16'h0000) ? LFSR_DEFAULT : seedgen;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour_count <= 6'd0;
    end else if (start) begin
      colour_count <= 6'd0;
    end else if (col_wr) begin
      colour_count <= colour_count + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        store[i] <= RED;
      end
    end else if (col_wr) begin
      store[colour_count[4:0]] <= colour_t'(lfsr[1:0]);
    end
  end

  // A new check_round means a new segment: drop whatever was pressed for the old one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      check_q <= 6'd0;
      pick    <= 4'b0000;
    end else begin
      check_q <= check_round;
      if (start || col_wr) begin
        pick <= 4'b0000;
      end else if (check_round != check_q) begin
        pick <= 4'b0000;
      end else if (player_input != 4'b0000) begin
        pick <= pick | player_input;
      end
    end
  end

  always_comb begin
    rd_idx     = 5'(colour_count - check_round);
    exp_colour = store[rd_idx];
    exp_oh     = onehot(exp_colour);
    result     = (pick == exp_oh);
    led        = 4'b0000;
    if (flash_clk) begin
      led = (pick != 4'b0000) ? pick : exp_oh;
    end
  end

  pulse_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_speed (load_speed),
    .flash_clk  (flash_clk),
    .speed      (speed),
    .pulse      (pulse)
  );

endmodule
